// File: rtl/wb_pkg.sv
// Shared types for the write-back queue: default widths, entry payload and
// drain FSM states.
package wb_pkg;

  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_ADDR_W = 5;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order entry storage for the write-back queue: up to two pushes and one pop
// per cycle, with the storage array exposed for the forwarding search.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = wb_entry_t,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push0,
  input  entry_t        push0_data,
  input  logic          push1,
  input  entry_t        push1_data,
  input  logic          pop,
  output entry_t        slots [DEPTH],
  output logic [PW-1:0] head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] tail;

  // Pointer and occupancy bookkeeping; push1 always lands after push0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(push0) + PW'(push1);
      head  <= head + PW'(pop);
      count <= count + CW'(push0) + CW'(push1) - CW'(pop);
    end
  end

  // Storage needs no reset: only slots below count are ever observed.
  always_ff @(posedge clk) begin
    if (rst && push0) slots[tail] <= push0_data;
    if (rst && push1) slots[tail + PW'(1)] <= push1_data;
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/wb_queue.sv
// Write-back queue: accepts load/ALU results in order, drains them into the
// register file write port, and forwards pending destinations to decode.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned DATA_W      = WB_DATA_W,
  parameter int unsigned ADDR_W      = WB_ADDR_W,
  parameter int unsigned ACK_TIMEOUT = 8,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_data,
  input  logic              rf_write_finish,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic              rs_pending,
  output logic              rt_pending,
  output logic [DATA_W-1:0] rs_fwd_data,
  output logic [DATA_W-1:0] rt_fwd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty,
  output logic              ack_err
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t        slots [DEPTH];
  logic [PW-1:0] head;
  logic          fifo_full;
  logic          fifo_empty;

  logic [CW-1:0] free;
  logic          mem_nz;
  logic          alu_nz;
  logic          mem_st;
  logic          alu_st;
  logic          push0;
  logic          push1;
  entry_t        push0_data;
  entry_t        push1_data;
  logic          pop;

  wb_state_t     state;
  wb_state_t     state_nxt;
  logic [TW-1:0] wait_cnt;
  logic [TW-1:0] wait_nxt;
  logic          err_nxt;
  logic [CW-1:0] cnt_nxt;

  // Acceptance: free space is taken before this cycle's pop; mem has priority.
  assign free      = CW'(DEPTH) - count;
  assign mem_nz    = (mem_rd != '0);
  assign alu_nz    = (alu_rd != '0);
  assign mem_ready = rst & (free >= CW'(1));
  assign alu_ready = rst & (free >= (CW'(1) + CW'(mem_valid & mem_nz)));
  assign mem_st    = mem_valid & mem_ready & mem_nz;
  assign alu_st    = alu_valid & alu_ready & alu_nz;

  always_comb begin
    push0      = mem_st | alu_st;
    push1      = mem_st & alu_st;
    push0_data = mem_st ? {mem_rd, mem_data} : {alu_rd, alu_data};
    push1_data = {alu_rd, alu_data};
  end

  wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push0      (push0),
    .push0_data (push0_data),
    .push1      (push1),
    .push1_data (push1_data),
    .pop        (pop),
    .slots      (slots),
    .head       (head),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ack_err  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      ack_err  <= err_nxt;
    end
  end

  // Drain FSM: pop on ack, or drop the head once it has waited ACK_TIMEOUT cycles.
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    err_nxt   = ack_err;
    pop       = 1'b0;
    if (rst && state == WRITE) begin
      if (rf_write_finish) begin
        pop      = 1'b1;
        wait_nxt = '0;
      end else if (wait_cnt == TW'(ACK_TIMEOUT - 1)) begin
        pop      = 1'b1;
        wait_nxt = '0;
        err_nxt  = 1'b1;
      end else begin
        wait_nxt = wait_cnt + TW'(1);
      end
    end
    cnt_nxt   = count + CW'(push0) + CW'(push1) - CW'(pop);
    state_nxt = (cnt_nxt != '0) ? WRITE : IDLE;
  end

  assign rf_write = rst & (state == WRITE);
  assign rf_rd    = rf_write ? slots[head].rd   : '0;
  assign rf_data  = rf_write ? slots[head].data : '0;
  assign full     = rst & fifo_full;
  assign empty    = ~rst | fifo_empty;

  logic              rs_hit;
  logic              rt_hit;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    rs_val = '0;
    rt_val = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (CW'(i) < count) begin
        if (slots[head + PW'(i)].rd == rs) begin
          rs_hit = 1'b1;
          rs_val = slots[head + PW'(i)].data;
        end
        if (slots[head + PW'(i)].rd == rt) begin
          rt_hit = 1'b1;
          rt_val = slots[head + PW'(i)].data;
        end
      end
    end
  end

  assign rs_pending  = rst & (rs != '0) & rs_hit;
  assign rt_pending  = rst & (rt != '0) & rt_hit;
  assign rs_fwd_data = rs_pending ? rs_val : '0;
  assign rt_fwd_data = rt_pending ? rt_val : '0;

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: vector table for acceptance, hand-written
// corner sequences, and a scoreboard of expected register-file writes.
module tb_wb_queue;

  localparam int DEPTH       = 4;
  localparam int ACK_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, alu_valid;
  logic [4:0]  mem_rd, alu_rd;
  logic [31:0] mem_data, alu_data;
  logic        mem_ready, alu_ready;
  logic        rf_write, rf_write_finish;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic [4:0]  rs, rt;
  logic        rs_pending, rt_pending;
  logic [31:0] rs_fwd_data, rt_fwd_data;
  logic [2:0]  count;
  logic        full, empty, ack_err;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] sb [$];

  always #5 clk = ~clk;

  wb_queue #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .rf_write(rf_write), .rf_rd(rf_rd), .rf_data(rf_data), .rf_write_finish(rf_write_finish),
    .rs(rs), .rt(rt), .rs_pending(rs_pending), .rt_pending(rt_pending),
    .rs_fwd_data(rs_fwd_data), .rt_fwd_data(rt_fwd_data),
    .count(count), .full(full), .empty(empty), .ack_err(ack_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
  endtask

  // Every acknowledged write must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst === 1'b1 && rf_write === 1'b1 && rf_write_finish === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL rf_unexpected: got rd=%0d data=0x%0h, required no write", rf_rd, rf_data);
      end else begin
        logic [36:0] exp;
        exp = sb.pop_front();
        if ({rf_rd, rf_data} !== exp) begin
          n_err++;
          $display("FAIL rf_order: got rd=%0d data=0x%0h, required rd=%0d data=0x%0h",
                   rf_rd, rf_data, exp[36:32], exp[31:0]);
        end
      end
    end
  end

  typedef struct {
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        e_mr;
    logic        e_ar;
    logic [2:0]  e_cnt;
    logic        e_full;
  } vec_t;

  vec_t tbl [4];

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    tbl[0] = '{1'b1, 5'd4,  32'h11, 1'b1, 5'd5,  32'h22, 1'b1, 1'b1, 3'd2, 1'b0};
    tbl[1] = '{1'b0, 5'd0,  32'h0,  1'b1, 5'd6,  32'h33, 1'b1, 1'b1, 3'd3, 1'b0};
    tbl[2] = '{1'b1, 5'd8,  32'h44, 1'b1, 5'd9,  32'h55, 1'b1, 1'b0, 3'd4, 1'b1};
    tbl[3] = '{1'b1, 5'd10, 32'h66, 1'b1, 5'd11, 32'h77, 1'b0, 1'b0, 3'd4, 1'b1};

    // Reset state
    rst = 1'b0; rf_write_finish = 1'b0; rs = '0; rt = '0;
    idle_inputs();
    cyc(); cyc();
    check("rst_count", count, 0);
    check("rst_rf_write", rf_write, 0);
    check("rst_mem_ready", mem_ready, 0);
    check("rst_alu_ready", alu_ready, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ack_err", ack_err, 0);
    rst = 1'b1; settle();
    check("post_rst_mem_ready", mem_ready, 1);

    // Single ALU write, rs pending for exactly one cycle
    rf_write_finish = 1'b1; rs = 5'd3;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD_BEEF;
    settle();
    check("single_alu_ready", alu_ready, 1);
    check("single_pending_pre", rs_pending, 0);
    sb.push_back({5'd3, 32'hDEAD_BEEF});
    cyc(); idle_inputs(); settle();
    check("single_rf_write", rf_write, 1);
    check("single_rf_rd", rf_rd, 3);
    check("single_rf_data", rf_data, 32'hDEAD_BEEF);
    check("single_pending", rs_pending, 1);
    check("single_fwd", rs_fwd_data, 32'hDEAD_BEEF);
    check("single_count", count, 1);
    cyc();
    check("single_empty", empty, 1);
    check("single_rf_write_off", rf_write, 0);
    check("single_pending_off", rs_pending, 0);
    check("single_fwd_off", rs_fwd_data, 0);
    rs = '0;

    // Acceptance table with the register file stalled
    rf_write_finish = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_valid = tbl[i].mv; mem_rd = tbl[i].mrd; mem_data = tbl[i].md;
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      settle();
      check($sformatf("tbl%0d_mem_ready", i), mem_ready, tbl[i].e_mr);
      check($sformatf("tbl%0d_alu_ready", i), alu_ready, tbl[i].e_ar);
      if (tbl[i].mv && tbl[i].e_mr && tbl[i].mrd != 0) sb.push_back({tbl[i].mrd, tbl[i].md});
      if (tbl[i].av && tbl[i].e_ar && tbl[i].ard != 0) sb.push_back({tbl[i].ard, tbl[i].ad});
      cyc();
      check($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
      check($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
    end
    idle_inputs(); rf_write_finish = 1'b1;
    k = 0;
    while (empty !== 1'b1 && k < 10) begin cyc(); k++; end
    check("tbl_drain_cycles", k, DEPTH);

    // Forwarding picks the youngest duplicate
    rf_write_finish = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA;
    sb.push_back({5'd7, 32'hA});
    cyc();
    alu_data = 32'hB;
    sb.push_back({5'd7, 32'hB});
    cyc(); idle_inputs();
    rs = 5'd7; rt = 5'd0; settle();
    check("fwd_rs_pending", rs_pending, 1);
    check("fwd_rs_data", rs_fwd_data, 32'hB);
    check("fwd_rt0_pending", rt_pending, 0);
    check("fwd_rt0_data", rt_fwd_data, 0);
    rt = 5'd7; settle();
    check("fwd_rt_data", rt_fwd_data, 32'hB);
    rs = '0; rt = '0;
    rf_write_finish = 1'b1;
    k = 0;
    while (empty !== 1'b1 && k < 10) begin cyc(); k++; end
    check("fwd_drain_cycles", k, 2);

    // rd==0 results accepted but never stored
    mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'h99;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h77;
    settle();
    check("rd0_mem_ready", mem_ready, 1);
    check("rd0_alu_ready", alu_ready, 1);
    cyc(); idle_inputs(); settle();
    check("rd0_count", count, 0);
    check("rd0_rf_write", rf_write, 0);
    cyc();
    check("rd0_rf_write_later", rf_write, 0);

    // Ack timeout drops the head and sets a sticky error
    rf_write_finish = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h55;
    cyc(); idle_inputs();
    check("to_err_before", ack_err, 0);
    k = 0;
    while (count != 0 && k < 20) begin cyc(); k++; end
    check("to_cycles", k, ACK_TIMEOUT);
    check("to_ack_err", ack_err, 1);
    check("to_rf_write", rf_write, 0);
    rf_write_finish = 1'b1;
    cyc(); cyc(); cyc();
    check("to_err_sticky", ack_err, 1);

    // Reset mid-drain discards the queue
    rf_write_finish = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd20; mem_data = 32'h1;
    alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'h2;
    cyc();
    mem_valid = 1'b0;
    alu_rd = 5'd22; alu_data = 32'h3;
    cyc(); idle_inputs(); settle();
    check("mid_count", count, 3);
    rs = 5'd20; rst = 1'b0; settle();
    check("mid_rst_rf_write", rf_write, 0);
    check("mid_rst_mem_ready", mem_ready, 0);
    check("mid_rst_alu_ready", alu_ready, 0);
    check("mid_rst_pending", rs_pending, 0);
    check("mid_rst_empty", empty, 1);
    cyc();
    check("mid_rst_count", count, 0);
    check("mid_rst_ack_err", ack_err, 0);
    check("mid_rst_rf_write2", rf_write, 0);
    cyc();
    rst = 1'b1; settle();
    check("mid_rel_mem_ready", mem_ready, 1);
    check("mid_rel_alu_ready", alu_ready, 1);
    check("mid_rel_count", count, 0);
    check("mid_rel_rf_write", rf_write, 0);
    rs = '0;

    cyc(); cyc();
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
